writeback_stage: RTL and testbench
==================================

WRITEBACK_STAGE -- requirements
Module: writeback_stage

Interface
REQ-001 i_clk  in  1  CPU clock; all state updates on rising edge.
REQ-002 i_rst_n  in  1  Reset, asynchronous and active-low.
REQ-003 i_valid  in  1  Upstream (memory stage) instruction valid.
REQ-004 o_ready  out  1  Stage can accept; an instruction transfers when i_valid && o_ready at a rising edge.
REQ-005 i_wb_en, i_rd_addr  in  1, 5  Instruction writes rd; destination register index.
REQ-006 i_wb_sel  in  2  Result source: 00 ALU, 01 load, 10 PC+4, 11 CSR read data.
REQ-007 i_alu_result, i_pc_plus4, i_csr_rdata  in  32 each  Candidate results.
REQ-008 i_funct3, i_addr_lo  in  3, 2  Load type; byte offset of load address.
REQ-009 i_dmem_ack, i_dmem_rdata  in  1, 32  Data-memory response strobe; aligned 32-bit word.
REQ-010 o_rd_wr_en, o_rd_addr, o_rd_data  out  1, 5, 32  Register-file write port, registered.
REQ-011 o_retire  out  1  One-cycle pulse per retired instruction.
REQ-012 o_load_fault  out  1  One-cycle pulse on misaligned or illegal load.

Function
REQ-013 The block SHALL implement states IDLE and WAIT_LOAD; o_ready SHALL be 1 only in IDLE.
REQ-014 IDLE, transfer with i_wb_sel!=01: next cycle o_rd_wr_en = i_wb_en && (i_rd_addr!=0), o_rd_addr = i_rd_addr, o_rd_data = selected source, o_retire=1; state stays IDLE (latency 1).
REQ-015 IDLE, transfer with i_wb_sel=01 and legal aligned load: capture rd_addr, wb_en, funct3, addr_lo; go to WAIT_LOAD; no write pulse.
REQ-016 Legal load types: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; 011, 110, 111 illegal.
REQ-017 Misaligned: LH/LHU with addr_lo[0]=1; LW with addr_lo!=00; LB/LBU never misaligned.
REQ-018 Illegal or misaligned load at transfer: next cycle o_load_fault=1, o_rd_wr_en=0, o_retire=0; state stays IDLE; no memory wait.
REQ-019 WAIT_LOAD with i_dmem_ack=1: next cycle write captured rd (gated by wb_en and rd!=0), o_retire=1, return to IDLE.
REQ-020 WAIT_LOAD with i_dmem_ack=0: hold state, o_rd_wr_en=0, o_retire=0, unbounded wait.
REQ-021 Byte lane = i_dmem_rdata[8*addr_lo +: 8]; halfword lane = i_dmem_rdata[16*addr_lo[1] +: 16].
REQ-022 LB/LH sign-extend to 32 bits; LBU/LHU zero-extend; LW passes word unchanged.
REQ-023 i_dmem_ack in IDLE SHALL be ignored.
REQ-024 The ack cycle SHALL NOT accept a new instruction (o_ready=0); the next instruction transfers no earlier than the following cycle.
REQ-025 o_rd_wr_en, o_retire, o_load_fault SHALL each be high for exactly one cycle per event and never simultaneously with o_load_fault and o_retire both 1.
REQ-026 o_rd_addr/o_rd_data SHALL hold last written values while o_rd_wr_en=0.

Reset
REQ-027 On i_rst_n=0, immediately: state IDLE, o_rd_wr_en=0, o_rd_addr=0, o_rd_data=0, o_retire=0, o_load_fault=0, captured load fields cleared.
REQ-028 Reset during WAIT_LOAD SHALL abandon the load; an ack after reset release SHALL be ignored.
REQ-029 o_ready SHALL be 1 in the first cycle after reset release.

Verification
REQ-030 ALU op: i_wb_sel=00, rd=5, alu=0x0000_1234 -> next cycle wr_en=1, addr=5, data=0x0000_1234, retire=1.
REQ-031 rd=0 with i_wb_sel=10, pc_plus4=0x80 -> wr_en=0, retire=1.
REQ-032 LB addr_lo=3, rdata=0x80FF_0000, ack after 3 cycles -> o_ready=0 for 4 cycles, then data=0xFFFF_FF80, wr_en=1; LBU same -> 0x0000_0080.
REQ-033 LH addr_lo=2, rdata=0x8001_7FFF -> 0xFFFF_8001; LHU -> 0x0000_8001; LW addr_lo=0 -> 0x8001_7FFF.
REQ-034 LW addr_lo=2 and funct3=011 -> load_fault=1 one cycle, wr_en=0, retire=0, o_ready stays 1.
REQ-035 Reset asserted in WAIT_LOAD, released, then spurious ack -> no write, no retire, all outputs 0.

Source files
------------

// File: rtl/writeback_stage_if.sv
// writeback_stage_if: memory-stage handshake, data-memory response and register-file write port.
//   i_valid/o_ready      instruction handshake (transfer on i_valid && o_ready)
//   i_wb_en, i_rd_addr   destination write enable and register index
//   i_wb_sel             result source: 00 ALU, 01 load, 10 PC+4, 11 CSR
//   i_alu_result, i_pc_plus4, i_csr_rdata  candidate results
//   i_funct3, i_addr_lo  load type and byte offset
//   i_dmem_ack, i_dmem_rdata  data-memory response
//   o_rd_wr_en, o_rd_addr, o_rd_data  registered register-file write port
//   o_retire, o_load_fault  one-cycle event pulses
interface writeback_stage_if;
    logic        i_valid;
    logic        o_ready;
    logic        i_wb_en;
    logic [4:0]  i_rd_addr;
    logic [1:0]  i_wb_sel;
    logic [31:0] i_alu_result;
    logic [31:0] i_pc_plus4;
    logic [31:0] i_csr_rdata;
    logic [2:0]  i_funct3;
    logic [1:0]  i_addr_lo;
    logic        i_dmem_ack;
    logic [31:0] i_dmem_rdata;
    logic        o_rd_wr_en;
    logic [4:0]  o_rd_addr;
    logic [31:0] o_rd_data;
    logic        o_retire;
    logic        o_load_fault;

    modport master (
        output i_valid, i_wb_en, i_rd_addr, i_wb_sel, i_alu_result, i_pc_plus4, i_csr_rdata,
               i_funct3, i_addr_lo, i_dmem_ack, i_dmem_rdata,
        input  o_ready, o_rd_wr_en, o_rd_addr, o_rd_data, o_retire, o_load_fault
    );

    modport slave (
        input  i_valid, i_wb_en, i_rd_addr, i_wb_sel, i_alu_result, i_pc_plus4, i_csr_rdata,
               i_funct3, i_addr_lo, i_dmem_ack, i_dmem_rdata,
        output o_ready, o_rd_wr_en, o_rd_addr, o_rd_data, o_retire, o_load_fault
    );
endinterface

// File: rtl/writeback_stage.sv
// writeback_stage: selects the result of a retiring instruction, waits for load data and drives the register-file write port.
//   i_clk    clock, all state updates on the rising edge
//   i_rst_n  asynchronous active-low reset
//   bus      writeback_stage_if.slave: upstream handshake, dmem response, register-file write port, retire/fault pulses
module writeback_stage (
    input  logic             i_clk,
    input  logic             i_rst_n,
    writeback_stage_if.slave bus
);
    typedef enum logic {IDLE = 1'b0, WAIT_LOAD = 1'b1} state_t;

    state_t      r_state, w_next;
    logic        r_ld_wb_en;
    logic [4:0]  r_ld_rd;
    logic [2:0]  r_ld_funct3;
    logic [1:0]  r_ld_addr_lo;
    logic        r_wr_en, r_retire, r_fault;
    logic [4:0]  r_rd_addr;
    logic [31:0] r_rd_data;

    logic        w_ready, w_xfer, w_is_load, w_illegal, w_misal, w_fault, w_ld_start;
    logic        w_alu_wr, w_ld_wr, w_wr_en;
    logic [4:0]  w_wr_addr;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_src, w_ld_data, w_wr_data;

    assign w_ready    = (r_state == IDLE);
    assign w_xfer     = bus.i_valid && w_ready;
    assign w_is_load  = (bus.i_wb_sel == 2'b01);
    // 011, 110 and 111 are the unused load encodings
    assign w_illegal  = (bus.i_funct3[1:0] == 2'b11) || (bus.i_funct3[2:1] == 2'b11);
    assign w_misal    = ((bus.i_funct3[1:0] == 2'b01) && bus.i_addr_lo[0]) ||
                        ((bus.i_funct3[1:0] == 2'b10) && (bus.i_addr_lo != 2'b00));
    assign w_fault    = w_xfer && w_is_load && (w_illegal || w_misal);
    assign w_ld_start = w_xfer && w_is_load && !w_illegal && !w_misal;

    assign w_byte    = bus.i_dmem_rdata[{r_ld_addr_lo, 3'b000} +: 8];
    assign w_half    = bus.i_dmem_rdata[{r_ld_addr_lo[1], 4'b0000} +: 16];
    // funct3[2] marks the unsigned variants, which suppress sign extension
    assign w_ld_data = (r_ld_funct3[1:0] == 2'b00) ? {{24{w_byte[7] & ~r_ld_funct3[2]}}, w_byte} :
                       (r_ld_funct3[1:0] == 2'b01) ? {{16{w_half[15] & ~r_ld_funct3[2]}}, w_half} :
                       bus.i_dmem_rdata;
    assign w_src     = (bus.i_wb_sel == 2'b00) ? bus.i_alu_result :
                       (bus.i_wb_sel == 2'b10) ? bus.i_pc_plus4 : bus.i_csr_rdata;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = (r_state == IDLE) ? (w_ld_start ? WAIT_LOAD : IDLE) :
                 (bus.i_dmem_ack ? IDLE : WAIT_LOAD);
    end

    always_comb begin
        w_alu_wr  = w_xfer && !w_is_load;
        w_ld_wr   = (r_state == WAIT_LOAD) && bus.i_dmem_ack;
        w_wr_en   = w_alu_wr ? (bus.i_wb_en && (bus.i_rd_addr != 5'd0)) :
                    (w_ld_wr && r_ld_wb_en && (r_ld_rd != 5'd0));
        w_wr_addr = w_alu_wr ? bus.i_rd_addr : r_ld_rd;
        w_wr_data = w_alu_wr ? w_src : w_ld_data;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ld_wb_en   <= 1'b0;
            r_ld_rd      <= 5'd0;
            r_ld_funct3  <= 3'd0;
            r_ld_addr_lo <= 2'd0;
        end else if (w_ld_start) begin
            r_ld_wb_en   <= bus.i_wb_en;
            r_ld_rd      <= bus.i_rd_addr;
            r_ld_funct3  <= bus.i_funct3;
            r_ld_addr_lo <= bus.i_addr_lo;
        end
    end

    // address/data only move on a real write so they hold the last written values
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_en   <= 1'b0;
            r_retire  <= 1'b0;
            r_fault   <= 1'b0;
            r_rd_addr <= 5'd0;
            r_rd_data <= 32'd0;
        end else begin
            r_wr_en  <= w_wr_en;
            r_retire <= w_alu_wr || w_ld_wr;
            r_fault  <= w_fault;
            if (w_wr_en) begin
                r_rd_addr <= w_wr_addr;
                r_rd_data <= w_wr_data;
            end
        end
    end

    assign bus.o_ready      = w_ready;
    assign bus.o_rd_wr_en   = r_wr_en;
    assign bus.o_rd_addr    = r_rd_addr;
    assign bus.o_rd_data    = r_rd_data;
    assign bus.o_retire     = r_retire;
    assign bus.o_load_fault = r_fault;
endmodule

// File: tb/tb_writeback_stage.sv
// tb_writeback_stage: randomized self-checking bench for writeback_stage against a behavioural model.
module tb_writeback_stage;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    writeback_stage_if bus();
    writeback_stage dut (.i_clk(clk), .i_rst_n(rst_n), .bus(bus.slave));

    int n_vec = 0;
    int n_err = 0;
    logic [4:0]  m_addr = 5'd0;
    logic [31:0] m_data = 32'd0;
    logic [40:0] obs, exp_v;

    function automatic logic [40:0] outs();
        return {bus.o_ready, bus.o_rd_wr_en, bus.o_rd_addr, bus.o_rd_data, bus.o_retire, bus.o_load_fault};
    endfunction

    function automatic logic [40:0] pack(logic rdy, logic we, logic ret, logic flt);
        return {rdy, we, m_addr, m_data, ret, flt};
    endfunction

    function automatic int ld_bytes(logic [2:0] f3);
        int w;
        w = (f3 % 4 == 0) ? 1 : (f3 % 4 == 1) ? 2 : 4;
        return w;
    endfunction

    function automatic bit m_fault(logic [2:0] f3, logic [1:0] lo);
        if (f3 == 3 || f3 == 6 || f3 == 7) return 1'b1;
        return (int'(lo) % ld_bytes(f3)) != 0;
    endfunction

    function automatic logic [31:0] m_load(logic [2:0] f3, logic [1:0] lo, logic [31:0] rdata);
        int w;
        logic [31:0] v;
        w = ld_bytes(f3);
        v = rdata >> ((w == 4) ? 0 : 8 * int'(lo));
        if (w == 1) begin
            v = v & 32'hFF;
            if (f3 < 4 && v >= 128) v = v | 32'hFFFF_FF00;
        end else if (w == 2) begin
            v = v & 32'hFFFF;
            if (f3 < 4 && v >= 32768) v = v | 32'hFFFF_0000;
        end
        return v;
    endfunction

    function automatic logic [31:0] m_src(logic [1:0] sel, logic [31:0] alu, logic [31:0] pc4, logic [31:0] csr);
        return (sel == 2'b00) ? alu : (sel == 2'b10) ? pc4 : csr;
    endfunction

    task automatic drive(logic v, logic we, logic [4:0] rd, logic [1:0] sel, logic [31:0] alu,
                         logic [31:0] pc4, logic [31:0] csr, logic [2:0] f3, logic [1:0] lo);
        bus.i_valid = v; bus.i_wb_en = we; bus.i_rd_addr = rd; bus.i_wb_sel = sel;
        bus.i_alu_result = alu; bus.i_pc_plus4 = pc4; bus.i_csr_rdata = csr;
        bus.i_funct3 = f3; bus.i_addr_lo = lo;
    endtask

    task automatic drive_junk();
        drive(1'b0, 1'($urandom), 5'($urandom), 2'($urandom), $urandom, $urandom, $urandom, 3'($urandom), 2'($urandom));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        drive_junk();
        bus.i_dmem_ack = 1'b0; bus.i_dmem_rdata = 32'd0;
        #2;
        obs = outs(); exp_v = pack(1'b1, 1'b0, 1'b0, 1'b0); n_vec++;
        if (obs !== exp_v) begin n_err++; $display("FAIL reset_state got %h exp %h", obs, exp_v); end
        tick();
        rst_n = 1'b1;
        drive(1'b1, 1'b1, 5'd9, 2'b11, 32'd0, 32'd0, 32'hDEAD_BEEF, 3'd0, 2'd0);
        tick();
        drive_junk();
        #2;
        rst_n = 1'b0;
        #1;
        m_addr = 5'd0; m_data = 32'd0;
        obs = outs(); exp_v = pack(1'b1, 1'b0, 1'b0, 1'b0); n_vec++;
        if (obs !== exp_v) begin n_err++; $display("FAIL async_reset got %h exp %h", obs, exp_v); end
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_alu();
        logic we; logic [4:0] rd; logic [1:0] sel; logic [31:0] alu, pc4, csr;
        for (int i = 0; i < 40; i++) begin
            we = 1'($urandom_range(0, 3) != 0); rd = 5'($urandom); sel = 2'($urandom_range(0, 2));
            if (sel == 2'b01) sel = 2'b11;
            alu = $urandom; pc4 = $urandom; csr = $urandom;
            if (i == 0) begin we = 1'b1; rd = 5'd5; sel = 2'b00; alu = 32'h0000_1234; end
            if (i == 1) begin we = 1'b1; rd = 5'd0; sel = 2'b10; pc4 = 32'h80; end
            drive(1'b1, we, rd, sel, alu, pc4, csr, 3'($urandom), 2'($urandom));
            tick();
            if (we && rd != 0) begin m_addr = rd; m_data = m_src(sel, alu, pc4, csr); end
            obs = outs(); exp_v = pack(1'b1, we && rd != 0, 1'b1, 1'b0); n_vec++;
            if (obs !== exp_v) begin n_err++; $display("FAIL alu_op[%0d] got %h exp %h", i, obs, exp_v); end
            drive_junk();
            tick();
            obs = outs(); exp_v = pack(1'b1, 1'b0, 1'b0, 1'b0); n_vec++;
            if (obs !== exp_v) begin n_err++; $display("FAIL alu_idle[%0d] got %h exp %h", i, obs, exp_v); end
        end
    endtask

    task automatic test_loads();
        logic we; logic [4:0] rd; logic [2:0] f3; logic [1:0] lo; logic [31:0] rdata; int dly;
        logic [2:0] d_f3 [5] = '{3'd0, 3'd4, 3'd1, 3'd5, 3'd2};
        logic [1:0] d_lo [5] = '{2'd3, 2'd3, 2'd2, 2'd2, 2'd0};
        for (int i = 0; i < 35; i++) begin
            we = 1'($urandom_range(0, 4) != 0); rd = 5'($urandom); rdata = $urandom; dly = $urandom_range(0, 4);
            do begin
                f3 = 3'($urandom); lo = 2'($urandom);
            end while (m_fault(f3, lo));
            if (i < 5) begin
                we = 1'b1; rd = 5'd7 + 5'(i); f3 = d_f3[i]; lo = d_lo[i];
                rdata = (i < 2) ? 32'h80FF_0000 : 32'h8001_7FFF; dly = (i < 2) ? 3 : 1;
            end
            drive(1'b1, we, rd, 2'b01, $urandom, $urandom, $urandom, f3, lo);
            tick();
            obs = outs(); exp_v = pack(1'b0, 1'b0, 1'b0, 1'b0); n_vec++;
            if (obs !== exp_v) begin n_err++; $display("FAIL load_accept[%0d] got %h exp %h", i, obs, exp_v); end
            drive_junk();
            for (int d = 0; d < dly; d++) begin
                bus.i_dmem_rdata = $urandom;
                tick();
                obs = outs(); n_vec++;
                if (obs !== exp_v) begin n_err++; $display("FAIL load_wait[%0d.%0d] got %h exp %h", i, d, obs, exp_v); end
            end
            bus.i_dmem_ack = 1'b1; bus.i_dmem_rdata = rdata;
            tick();
            bus.i_dmem_ack = 1'b0; bus.i_dmem_rdata = $urandom;
            if (we && rd != 0) begin m_addr = rd; m_data = m_load(f3, lo, rdata); end
            obs = outs(); exp_v = pack(1'b1, we && rd != 0, 1'b1, 1'b0); n_vec++;
            if (obs !== exp_v) begin n_err++; $display("FAIL load_data[%0d] f3=%0d lo=%0d got %h exp %h", i, f3, lo, obs, exp_v); end
            tick();
            obs = outs(); exp_v = pack(1'b1, 1'b0, 1'b0, 1'b0); n_vec++;
            if (obs !== exp_v) begin n_err++; $display("FAIL load_after[%0d] got %h exp %h", i, obs, exp_v); end
        end
    endtask

    task automatic test_fault();
        logic [2:0] f3; logic [1:0] lo;
        for (int i = 0; i < 20; i++) begin
            do begin
                f3 = 3'($urandom); lo = 2'($urandom);
            end while (!m_fault(f3, lo));
            if (i == 0) begin f3 = 3'd2; lo = 2'd2; end
            if (i == 1) begin f3 = 3'd3; lo = 2'd0; end
            drive(1'b1, 1'b1, 5'($urandom_range(1, 31)), 2'b01, $urandom, $urandom, $urandom, f3, lo);
            tick();
            obs = outs(); exp_v = pack(1'b1, 1'b0, 1'b0, 1'b1); n_vec++;
            if (obs !== exp_v) begin n_err++; $display("FAIL load_fault[%0d] f3=%0d lo=%0d got %h exp %h", i, f3, lo, obs, exp_v); end
            drive_junk();
            bus.i_dmem_ack = 1'b1; bus.i_dmem_rdata = $urandom;
            tick();
            bus.i_dmem_ack = 1'b0;
            obs = outs(); exp_v = pack(1'b1, 1'b0, 1'b0, 1'b0); n_vec++;
            if (obs !== exp_v) begin n_err++; $display("FAIL fault_after[%0d] got %h exp %h", i, obs, exp_v); end
        end
    endtask

    task automatic test_ack_idle();
        drive_junk();
        for (int i = 0; i < 5; i++) begin
            bus.i_dmem_ack = 1'b1; bus.i_dmem_rdata = $urandom;
            tick();
            obs = outs(); exp_v = pack(1'b1, 1'b0, 1'b0, 1'b0); n_vec++;
            if (obs !== exp_v) begin n_err++; $display("FAIL ack_idle[%0d] got %h exp %h", i, obs, exp_v); end
        end
        bus.i_dmem_ack = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [4:0] rd; logic [1:0] sel; logic [31:0] alu, pc4, csr, rdata; logic [2:0] f3; logic [1:0] lo;
        for (int i = 0; i < 20; i++) begin
            rd = 5'($urandom); sel = (i % 2 == 0) ? 2'b00 : 2'b11; alu = $urandom; pc4 = $urandom; csr = $urandom;
            drive(1'b1, 1'b1, rd, sel, alu, pc4, csr, 3'($urandom), 2'($urandom));
            tick();
            if (rd != 0) begin m_addr = rd; m_data = m_src(sel, alu, pc4, csr); end
            obs = outs(); exp_v = pack(1'b1, rd != 0, 1'b1, 1'b0); n_vec++;
            if (obs !== exp_v) begin n_err++; $display("FAIL b2b_alu[%0d] got %h exp %h", i, obs, exp_v); end
        end
        for (int i = 0; i < 6; i++) begin
            do begin
                f3 = 3'($urandom); lo = 2'($urandom);
            end while (m_fault(f3, lo));
            rdata = $urandom;
            drive(1'b1, 1'b1, 5'd17, 2'b01, $urandom, $urandom, $urandom, f3, lo);
            tick();
            rd = 5'($urandom_range(1, 31)); alu = $urandom;
            drive(1'b1, 1'b1, rd, 2'b00, alu, $urandom, $urandom, 3'($urandom), 2'($urandom));
            tick();
            obs = outs(); exp_v = pack(1'b0, 1'b0, 1'b0, 1'b0); n_vec++;
            if (obs !== exp_v) begin n_err++; $display("FAIL b2b_hold[%0d] got %h exp %h", i, obs, exp_v); end
            bus.i_dmem_ack = 1'b1; bus.i_dmem_rdata = rdata;
            tick();
            bus.i_dmem_ack = 1'b0;
            m_addr = 5'd17; m_data = m_load(f3, lo, rdata);
            obs = outs(); exp_v = pack(1'b1, 1'b1, 1'b1, 1'b0); n_vec++;
            if (obs !== exp_v) begin n_err++; $display("FAIL b2b_load[%0d] got %h exp %h", i, obs, exp_v); end
            tick();
            m_addr = rd; m_data = alu;
            obs = outs(); exp_v = pack(1'b1, 1'b1, 1'b1, 1'b0); n_vec++;
            if (obs !== exp_v) begin n_err++; $display("FAIL b2b_next[%0d] got %h exp %h", i, obs, exp_v); end
            drive_junk();
            tick();
        end
    endtask

    task automatic test_reset_wait();
        drive(1'b1, 1'b1, 5'd12, 2'b01, $urandom, $urandom, $urandom, 3'd2, 2'd0);
        tick();
        drive_junk();
        obs = outs(); exp_v = pack(1'b0, 1'b0, 1'b0, 1'b0); n_vec++;
        if (obs !== exp_v) begin n_err++; $display("FAIL rstw_wait got %h exp %h", obs, exp_v); end
        #2;
        rst_n = 1'b0;
        #1;
        m_addr = 5'd0; m_data = 32'd0;
        obs = outs(); exp_v = pack(1'b1, 1'b0, 1'b0, 1'b0); n_vec++;
        if (obs !== exp_v) begin n_err++; $display("FAIL rstw_reset got %h exp %h", obs, exp_v); end
        tick();
        rst_n = 1'b1;
        bus.i_dmem_ack = 1'b1; bus.i_dmem_rdata = $urandom;
        tick();
        bus.i_dmem_ack = 1'b0;
        obs = outs(); n_vec++;
        if (obs !== exp_v) begin n_err++; $display("FAIL rstw_spurious_ack got %h exp %h", obs, exp_v); end
        tick();
        obs = outs(); n_vec++;
        if (obs !== exp_v) begin n_err++; $display("FAIL rstw_after got %h exp %h", obs, exp_v); end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_loads();
        test_fault();
        test_ack_idle();
        test_back_to_back();
        test_reset_wait();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
